// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Result c = {remainder, quotient}; latency WIDTH+1 cycles from accept to out_valid.
// A synchronous flush cancels any operation and returns to idle.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;     // dividend shifts out the top, quotient in the bottom
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [WIDTH-1:0]     raw_a_q, raw_a_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 dz_q, dz_d;
  logic [2*WIDTH-1:0]   c_q, c_d;

  logic [WIDTH:0]       partial;
  logic [WIDTH:0]       diff;
  logic                 in_sign_a, in_sign_b;
  logic [WIDTH-1:0]     fix_q, fix_r;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign c         = c_q;

  // One restoring step: shift next dividend bit into the partial remainder, trial-subtract.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvsr_q};
  end

  // Next-state and datapath updates; flush overrides every handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    raw_a_d  = raw_a_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    c_d      = c_q;
    fix_q    = '0;
    fix_r    = '0;

    in_sign_a = signed_en & a[WIDTH-1];
    in_sign_b = signed_en & b[WIDTH-1];

    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          state_d  = StBusy;
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = in_sign_a ? (~a + One) : a;
          dvsr_d   = in_sign_b ? (~b + One) : b;
          raw_a_d  = a;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          dz_d     = (b == '0);
        end
      end
      StBusy: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = partial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
          // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
          fix_q = (sign_a_q ^ sign_b_q) ? (~quo_d + One) : quo_d;
          fix_r = sign_a_q ? (~rem_d + One) : rem_d;
          if (!flush) begin
            c_d = dz_q ? {raw_a_q, {WIDTH{1'b1}}} : {fix_r, fix_q};
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      raw_a_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      raw_a_q  <= raw_a_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      c_q      <= c_d;
    end
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 divider, the counterpart of the multiplier datapath in the execute unit. It computes quotient and remainder for DIV/DIVU and returns them packed as a {HI, LO} pair, with remainder in the upper half and quotient in the lower half. It sits beside the multiplier in the MDU, with a valid/ready handshake on each side, a fixed latency, and a synchronous flush so the pipeline can cancel an in-flight divide on exception.

## Interface
- WIDTH, 32, operand width; result width is 2*WIDTH
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  reset; asynchronous, active-low
- flush  input  1  synchronous cancel of any operation in progress
- in_valid  input  1  operands and signed_en valid
- in_ready  output  1  divider able to accept (high only in IDLE)
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- signed_en  input  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- c  output  2*WIDTH  {remainder, quotient}

## Operation
- States:
  - IDLE -> BUSY on in_valid && in_ready.
  - BUSY -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE on out_valid && out_ready.
  - flush from any state -> IDLE.
- Outputs by state:
  - in_ready = (state == IDLE); combinational from state.
  - out_valid = (state == DONE).
- On accept, latch:
  - the sign of a and the sign of b (each zero when signed_en = 0);
  - |a| and |b| as WIDTH-bit unsigned magnitudes;
  - a raw copy of a, and a divide-by-zero flag (b == 0).
- BUSY iteration (one per cycle, restoring):
  - Form the WIDTH+1-bit partial remainder {rem, next dividend MSB}.
  - Subtract |b|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - The iteration counter runs 0..WIDTH-1.
- Sign fix-up, applied on the BUSY -> DONE transition:
  - Quotient is negated if signed_en and sign(a) != sign(b).
  - Remainder is negated if signed_en and sign(a) = 1; the remainder always takes the dividend's sign.
- Divide by zero overrides the datapath result for both signed_en values: quotient = all ones, remainder = raw a. Latency is unchanged.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = 0x80000000, remainder = 0. This is the natural wrap; no special case.
- c is registered. It is held stable throughout DONE and until the next BUSY -> DONE transition.
- flush:
  - Priority over every handshake in the same cycle.
  - Discards the operation; no result is ever presented for it.
  - If flush and in_valid are both high in IDLE, nothing is accepted.

## Timing
- Reset (resetn low, asynchronous):
  - state = IDLE, out_valid = 0, c = 0, counter = 0, so in_ready = 1.
  - Reset asserted mid-operation aborts it immediately.
- Latency: accept at edge E0; BUSY spans edges E1..E32 (WIDTH = 32); out_valid = 1 in the cycle after E32. Total latency is WIDTH+1 cycles from accept to out_valid.
- No overlap: in_ready is 0 from the cycle after accept until the cycle after the output handshake. The earliest next accept is one cycle after the output handshake.
- Output back-pressure: with out_ready low, out_valid stays 1 and c stays constant indefinitely.
- A flush asserted in cycle k puts in_ready = 1 and out_valid = 0 from cycle k+1.

## Test plan
- Unsigned divide: a = 100, b = 7, signed_en = 0 -> c = 0x00000002_0000000E; out_valid rises exactly 33 cycles after accept; in_ready = 0 throughout.
- Signed divide: a = -7 (0xFFFFFFF9), b = 2, signed_en = 1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also a = 7, b = -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero and overflow:
  - a = 0x12345678, b = 0, signed_en = 1 -> c = 0x12345678_FFFFFFFF, latency 33.
  - a = 0x80000000, b = 0xFFFFFFFF, signed_en = 1 -> c = 0x00000000_80000000.
- Back-pressure: hold out_ready = 0 for 5 cycles after out_valid -> c and out_valid are stable; in_ready = 0. Release -> IDLE next cycle; a new op is accepted the cycle after.
- Flush and reset:
  - Flush in BUSY iteration 10 -> out_valid is never asserted for that op; in_ready = 1 next cycle. A following 100/7 gives correct c.
  - resetn pulsed low mid-BUSY -> out_valid = 0, c = 0, in_ready = 1 immediately.
- Random regression: 10k random a, b, signed_en (including b = 0 and the overflow corner) with random out_ready and flush, checked against a reference model.
